bin_to_deci_decoder_buf: RTL and testbench

- Buffered 4:10 binary(BCD)-to-decimal decoder; the inverse of the team's 10:4 decimal-to-binary encoder.
- Accepts 4-bit codes over a valid/ready handshake, decodes each to a 10-bit one-hot decimal vector and queues results in a small FIFO.
- Delivers results over a second valid/ready handshake.
- Sits between digit-producing logic (counters, keypad encoder paths) and one-hot consumers (7-seg/lamp drivers).

---
 rtl/bin_to_deci_pkg.sv | 21 ++
 rtl/bcd_onehot_lut.sv | 24 ++
 rtl/bin_to_deci_decoder_buf.sv | 84 ++++++++
 tb/tb_bin_to_deci_decoder_buf.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bin_to_deci_pkg.sv
// Shared types and constants for the buffered BCD-to-one-hot decoder.
// Used by bcd_onehot_lut and bin_to_deci_decoder_buf.
package bin_to_deci_pkg;

  localparam int CODE_W    = 4;
  localparam int ONEHOT_W  = 10;
  localparam int MAX_DIGIT = 9;
  localparam int ENTRY_W   = ONEHOT_W + 1;

  typedef struct packed {
    logic                err;
    logic [ONEHOT_W-1:0] onehot;
  } entry_t;

  function automatic logic code_is_valid(
    input logic [CODE_W-1:0] code
  );
    return code <= CODE_W'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_onehot_lut.sv
// Combinational 4-bit code to {err, one-hot decimal} lookup.
// Invalid codes map to an all-zero vector with err set.
module bcd_onehot_lut
  import bin_to_deci_pkg::*;
(
  input  logic [CODE_W-1:0] in_code,
  output entry_t            entry
);

  always_comb begin
    entry = '0;
    unique case (1'b1)
      code_is_valid(in_code): begin
        entry.err    = 1'b0;
        entry.onehot = ONEHOT_W'(1) << in_code;
      end
      default: begin
        entry.err    = 1'b1;
        entry.onehot = '0;
      end
    endcase
  end

endmodule

// File: rtl/bin_to_deci_decoder_buf.sv
// Buffered BCD-to-one-hot decoder with valid/ready FIFO.
// Define BIN_TO_DECI_ERR_CNT_EN to enable the invalid-code counter.
module bin_to_deci_decoder_buf
  import bin_to_deci_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ONEHOT_W-1:0] out_D,
  output logic                out_err,
  output logic [ERR_W-1:0]    err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t            mem [DEPTH];
  entry_t            lut_out;
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;

  bcd_onehot_lut u_lut (
    .in_code (in_code),
    .entry   (lut_out)
  );

  assign in_ready  = !rst && (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];
  assign out_D     = out_valid ? head.onehot : '0;
  assign out_err   = out_valid ? head.err : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= lut_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef BIN_TO_DECI_ERR_CNT_EN
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (push && lut_out.err && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_bin_to_deci_decoder_buf.sv
// Randomized and directed bench for bin_to_deci_decoder_buf.
// Reference model is a queue of accepted codes plus an error tally.
module tb_bin_to_deci_decoder_buf;

  localparam int DEPTH = 4;
  localparam int ERR_W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_code = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [9:0]   out_D;
  logic         out_err;
  logic [ERR_W-1:0] err_cnt;

  int q[$];
  int errs = 0;
  int n_chk = 0;
  int n_pass = 0;

  bin_to_deci_decoder_buf #(
    .DEPTH (DEPTH),
    .ERR_W (ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_D     (out_D),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] exp_d(input int code);
    return (code <= 9) ? (32'd1 << code) : 32'd0;
  endfunction

  task automatic step(
    input logic       r,
    input logic       iv,
    input logic [3:0] c,
    input logic       ordy
  );
    logic acc;
    logic pop;
    int   head;
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_code   = c;
    out_ready = ordy;
    #1;
    head = (q.size() != 0) ? q[0] : -1;
    check("in_ready", 32'(in_ready),
          32'(!r && q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("out_D", 32'(out_D), (head < 0) ? 32'd0 : exp_d(head));
    check("out_err", 32'(out_err), 32'(head > 9));
    check("err_cnt", 32'(err_cnt), 32'(errs));
    acc = !r && iv && (q.size() < DEPTH);
    pop = ordy && (q.size() != 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      errs = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(int'(c));
`ifdef BIN_TO_DECI_ERR_CNT_EN
        if (c > 4'd9 && errs < (1 << ERR_W) - 1) errs++;
`endif
      end
    end
  endtask

  initial begin
    int bp[4];
    bp = '{3, 7, 9, 2};
    @(posedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    for (int i = 0; i < 10; i++) step(0, 1, 4'(i), 1);
    step(0, 0, 0, 1);

    step(0, 1, 4'd10, 1);
    step(0, 1, 4'd15, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    for (int i = 0; i < 4; i++) step(0, 1, 4'(bp[i]), 0);
    step(0, 1, 4'd5, 0);
    step(0, 1, 4'd5, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    step(0, 1, 4'd1, 0);
    step(0, 1, 4'd8, 0);
    step(0, 1, 4'd4, 1);
    for (int i = 0; i < 19; i++)
      step(0, 1, 4'($urandom_range(0, 9)), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    for (int i = 0; i < 3; i++) step(0, 1, 4'd11, 0);
    step(1, 1, 4'd3, 0);
    step(0, 1, 4'd6, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    for (int i = 0; i < 5; i++)
      step(0, 1, 4'($urandom_range(10, 15)), 1);
    step(0, 0, 0, 1);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
